// File: rtl/rom_read_sequencer.sv
// ROM read sequencer: walks ROM addresses 0..LAST_ADDR, drives CE/OE strobes,
// holds each address for ACCESS_CYCLES clocks, captures the byte and streams it
// out on a valid/ready port. address_line mirrors rom_addr for the display.
// Ports: clk, reset (sync, active-high), start; rom_addr/rom_ce_n/rom_oe_n/
// rom_data to the chip; out_data/out_valid/out_ready stream; address_line,
// busy, done status.
// Optional: `define ROM_SEQ_CHECKSUM_EN appends a 16-bit checksum (lo, hi)
// to the stream after the last ROM byte.
module rom_read_sequencer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int ACCESS_CYCLES = 4,
    parameter int LAST_ADDR     = 511
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] address_line,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_WAIT   = 3'd2,
        S_OUTPUT = 3'd3,
        S_DONE   = 3'd4
`ifdef ROM_SEQ_CHECKSUM_EN
        ,
        S_CKS_LO = 3'd5,
        S_CKS_HI = 3'd6
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [7:0]            CNT_INIT = 8'(ACCESS_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    xfer;
`ifdef ROM_SEQ_CHECKSUM_EN
    logic [15:0]             cks_q, cks_d;
`endif

    assign xfer = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef ROM_SEQ_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETUP;
                    addr_d  = '0;
`ifdef ROM_SEQ_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rom_data is only trusted once the access time has elapsed
                if (cnt_q == 8'd0) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_OUTPUT: begin
                if (xfer) begin
                    valid_d = 1'b0;
`ifdef ROM_SEQ_CHECKSUM_EN
                    cks_d   = cks_q + 16'(data_q);
`endif
                    if (addr_q == LAST) begin
`ifdef ROM_SEQ_CHECKSUM_EN
                        // present the low byte of the final sum right away
                        data_d  = DATA_WIDTH'(cks_d[7:0]);
                        valid_d = 1'b1;
                        state_d = S_CKS_LO;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_SETUP;
                    end
                end
            end
`ifdef ROM_SEQ_CHECKSUM_EN
            S_CKS_LO: begin
                if (xfer) begin
                    data_d  = DATA_WIDTH'(cks_q[15:8]);
                    state_d = S_CKS_HI;
                end
            end
            S_CKS_HI: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef ROM_SEQ_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef ROM_SEQ_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // strobes are asserted only while the chip is being accessed
    assign rom_ce_n     = !((state_q == S_SETUP) || (state_q == S_WAIT));
    assign rom_oe_n     = rom_ce_n;
    assign rom_addr     = addr_q;
    assign address_line = addr_q;
    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
